// File: rtl/seven_segment_scanner_if.sv
// Display-side bundle for the seven-segment scanner: digit data and enables in,
// multiplexed anode/segment drive and the frame pulse out.
interface seven_segment_scanner_if;
    logic [31:0] digit;
    logic [7:0]  en_dot;
    logic [7:0]  en_digit;
    logic [7:0]  an;
    logic [6:0]  seg;
    logic        dp;
    logic        frame_tick;

    modport slave (
        input  digit,
        input  en_dot,
        input  en_digit,
        output an,
        output seg,
        output dp,
        output frame_tick
    );

    modport master (
        output digit,
        output en_dot,
        output en_digit,
        input  an,
        input  seg,
        input  dp,
        input  frame_tick
    );
endinterface

// File: rtl/seven_segment_scanner.sv
// Eight-digit common-anode seven-segment scanner: per-frame input snapshot,
// blanking gap at the start of every slot, active-low registered drive.
module seven_segment_scanner #(
    parameter int unsigned REFRESH_DIV  = 100000,
    parameter int unsigned BLANK_CYCLES = 1000
) (
    input  logic                    clk,
    input  logic                    rst,
    seven_segment_scanner_if.slave  disp
);

    localparam int unsigned CNT_W = (REFRESH_DIV > 32'd1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CNT_W-1:0] DIV_LAST  = CNT_W'(REFRESH_DIV - 32'd1);
    localparam logic [CNT_W-1:0] BLANK_LIM = CNT_W'(BLANK_CYCLES);

    logic [CNT_W-1:0] div_cnt_q, div_cnt_d;
    logic [2:0]       idx_q, idx_d;
    logic [31:0]      snap_digit_q, snap_digit_d;
    logic [7:0]       snap_dot_q, snap_dot_d;
    logic [7:0]       snap_en_q, snap_en_d;
    logic [7:0]       an_q, an_d;
    logic [6:0]       seg_q, seg_d;
    logic             dp_q, dp_d;
    logic             frame_tick_q, frame_tick_d;

    logic             frame_start_s;
    logic             blank_s;
    logic [3:0]       cur_nib_s;

    // Hex nibble to active-low gfedcba pattern.
    function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
        logic [6:0] pat;
        case (nib)
            4'h0:    pat = 7'b1000000;
            4'h1:    pat = 7'b1111001;
            4'h2:    pat = 7'b0100100;
            4'h3:    pat = 7'b0110000;
            4'h4:    pat = 7'b0011001;
            4'h5:    pat = 7'b0010010;
            4'h6:    pat = 7'b0000010;
            4'h7:    pat = 7'b1111000;
            4'h8:    pat = 7'b0000000;
            4'h9:    pat = 7'b0010000;
            4'hA:    pat = 7'b0001000;
            4'hB:    pat = 7'b0000011;
            4'hC:    pat = 7'b1000110;
            4'hD:    pat = 7'b0100001;
            4'hE:    pat = 7'b0000110;
            4'hF:    pat = 7'b0001110;
            default: pat = 7'b1111111;
        endcase
        return pat;
    endfunction

    // Slot divider and position index; index advances only when the divider wraps.
    always_comb begin
        div_cnt_d = div_cnt_q;
        idx_d     = idx_q;
        if (div_cnt_q == DIV_LAST) begin
            div_cnt_d = '0;
            idx_d     = idx_q + 3'd1;
        end else begin
            div_cnt_d = div_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
            idx_d     = idx_q;
        end
    end

    // Inputs are captured only at the top of a frame so one frame never mixes two updates.
    always_comb begin
        frame_start_s = (div_cnt_q == '0) && (idx_q == 3'd0);
        snap_digit_d  = snap_digit_q;
        snap_dot_d    = snap_dot_q;
        snap_en_d     = snap_en_q;
        frame_tick_d  = frame_start_s;
        if (frame_start_s) begin
            snap_digit_d = disp.digit;
            snap_dot_d   = disp.en_dot;
            snap_en_d    = disp.en_digit;
        end else begin
            snap_digit_d = snap_digit_q;
            snap_dot_d   = snap_dot_q;
            snap_en_d    = snap_en_q;
        end
    end

    // Display drive: dark during the blanking gap or for disabled positions.
    always_comb begin
        cur_nib_s = snap_digit_q[{idx_q, 2'b00} +: 4];
        blank_s   = (div_cnt_q < BLANK_LIM) || !snap_en_q[idx_q];
        an_d      = 8'hFF;
        seg_d     = 7'h7F;
        dp_d      = 1'b1;
        if (blank_s) begin
            an_d  = 8'hFF;
            seg_d = 7'h7F;
            dp_d  = 1'b1;
        end else begin
            an_d  = ~(8'h01 << idx_q);
            seg_d = hex_to_seg(cur_nib_s);
            dp_d  = ~snap_dot_q[idx_q];
        end
    end

    // State and output registers; reset forces every anode and segment off.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            div_cnt_q    <= '0;
            idx_q        <= 3'd0;
            snap_digit_q <= 32'h0000_0000;
            snap_dot_q   <= 8'h00;
            snap_en_q    <= 8'h00;
            an_q         <= 8'hFF;
            seg_q        <= 7'h7F;
            dp_q         <= 1'b1;
            frame_tick_q <= 1'b0;
        end else begin
            div_cnt_q    <= div_cnt_d;
            idx_q        <= idx_d;
            snap_digit_q <= snap_digit_d;
            snap_dot_q   <= snap_dot_d;
            snap_en_q    <= snap_en_d;
            an_q         <= an_d;
            seg_q        <= seg_d;
            dp_q         <= dp_d;
            frame_tick_q <= frame_tick_d;
        end
    end

    assign disp.an         = an_q;
    assign disp.seg        = seg_q;
    assign disp.dp         = dp_q;
    assign disp.frame_tick = frame_tick_q;

endmodule
